// File: rtl/bipartite_route_scheduler.sv
// ---------------------------------------------------------------------------
// bipartite_route_scheduler
//
// Purpose: sequences one input-to-output route at a time through a 16x16
// complete-bipartite fluidic crossbar. Pending requests are arbitrated
// round-robin. Each granted route runs prime (output valve only), flow
// (input and output valves), then drain (output valve only). Only one source
// is ever connected to the fabric.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-input route request, held until granted
//   req_dst        packed destination per input (DST_W bits per input)
//   dwell_cycles   flow duration, sampled at grant (0 is treated as 1)
//   abort          ends the active route early (PRIME/FLOW only)
//   grant          one-cycle one-hot pulse to the winning requester
//   in_valve       one-hot input-side valve enable
//   out_valve      one-hot output-side valve enable
//   busy           high whenever the scheduler is not IDLE
//   done           one-cycle pulse on route completion
//   done_src/dst   source/destination of the completed route
//   done_aborted   completed route was aborted
//   route_count    completed routes, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module bipartite_route_scheduler #(
   parameter int N_IN    = 16,
   parameter int N_OUT   = 16,
   parameter int SETTLE  = 4,
   parameter int DWELL_W = 16,
   localparam int SRC_W  = $clog2(N_IN),
   localparam int DST_W  = $clog2(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_IN-1:0]        req_valid,
   input  logic [N_IN*DST_W-1:0]  req_dst,
   input  logic [DWELL_W-1:0]     dwell_cycles,
   input  logic                   abort,
   output logic [N_IN-1:0]        grant,
   output logic [N_IN-1:0]        in_valve,
   output logic [N_OUT-1:0]       out_valve,
   output logic                   busy,
   output logic                   done,
   output logic [SRC_W-1:0]       done_src,
   output logic [DST_W-1:0]       done_dst,
   output logic                   done_aborted,
   output logic [15:0]            route_count
);

   // The phase counter has to hold both SETTLE-1 and a full dwell value.
   localparam int CNT_W = (DWELL_W > $clog2(SETTLE + 1)) ? DWELL_W : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_FLOW, S_DRAIN} state_t;

   state_t               r_state, w_state_next;
   logic [CNT_W-1:0]     r_cnt, w_cnt_next;
   logic [SRC_W-1:0]     r_src, w_src_next;
   logic [DST_W-1:0]     r_dst, w_dst_next;
   logic [DWELL_W-1:0]   r_dwm1, w_dwm1_next;
   logic [SRC_W-1:0]     r_ptr, w_ptr_next;
   logic                 r_aborted, w_aborted_next;
   logic                 w_grant_fire, w_done_fire;

   logic [N_IN-1:0]      r_grant, w_grant_next;
   logic [N_IN-1:0]      r_in_valve, w_in_valve_next;
   logic [N_OUT-1:0]     r_out_valve, w_out_valve_next;
   logic                 r_busy;
   logic                 r_done;
   logic [SRC_W-1:0]     r_done_src;
   logic [DST_W-1:0]     r_done_dst;
   logic                 r_done_aborted;
   logic [15:0]          r_route_count;

   // Unpack per-input destinations.
   logic [DST_W-1:0]     w_dst_arr [N_IN];
   for (genvar gi = 0; gi < N_IN; gi++) begin : g_dst
      assign w_dst_arr[gi] = req_dst[gi*DST_W +: DST_W];
   end

   // Round-robin pick: first requester at or after the pointer, wrapping.
   // Wrap is free because N_IN is a power of two.
   logic [SRC_W-1:0]     w_pick, w_cand;
   logic                 w_found;
   always_comb begin
      w_pick  = '0;
      w_cand  = '0;
      w_found = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         w_cand = r_ptr + SRC_W'(k);
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   // Next-state logic; outputs are derived from the next state so they come
   // straight out of registers.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_src_next     = r_src;
      w_dst_next     = r_dst;
      w_dwm1_next    = r_dwm1;
      w_ptr_next     = r_ptr;
      w_aborted_next = r_aborted;
      w_grant_fire   = 1'b0;
      w_done_fire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_next   = S_PRIME;
               w_cnt_next     = SETTLE_M1;
               w_src_next     = w_pick;
               w_dst_next     = w_dst_arr[w_pick];
               // Store D-1 with D = max(dwell, 1).
               w_dwm1_next    = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);
               w_ptr_next     = w_pick + SRC_W'(1);
               w_aborted_next = 1'b0;
               w_grant_fire   = 1'b1;
            end
         end
         S_PRIME, S_FLOW: begin
            // Abort wins over a natural phase change on the same edge.
            if (abort) begin
               w_state_next   = S_DRAIN;
               w_cnt_next     = SETTLE_M1;
               w_aborted_next = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_next = (r_state == S_PRIME) ? S_FLOW : S_DRAIN;
               w_cnt_next   = (r_state == S_PRIME) ? CNT_W'(r_dwm1) : SETTLE_M1;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (r_cnt == '0) begin
               w_state_next = S_IDLE;
               w_done_fire  = 1'b1;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      w_grant_next = '0;
      if (w_grant_fire) w_grant_next[w_pick] = 1'b1;
      w_in_valve_next = '0;
      if (w_state_next == S_FLOW) w_in_valve_next[w_src_next] = 1'b1;
      w_out_valve_next = '0;
      if (w_state_next != S_IDLE) w_out_valve_next[w_dst_next] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_src          <= '0;
         r_dst          <= '0;
         r_dwm1         <= '0;
         r_ptr          <= '0;
         r_aborted      <= 1'b0;
         r_grant        <= '0;
         r_in_valve     <= '0;
         r_out_valve    <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_done_src     <= '0;
         r_done_dst     <= '0;
         r_done_aborted <= 1'b0;
         r_route_count  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_src       <= w_src_next;
         r_dst       <= w_dst_next;
         r_dwm1      <= w_dwm1_next;
         r_ptr       <= w_ptr_next;
         r_aborted   <= w_aborted_next;
         r_grant     <= w_grant_next;
         r_in_valve  <= w_in_valve_next;
         r_out_valve <= w_out_valve_next;
         r_busy      <= (w_state_next != S_IDLE);
         r_done      <= w_done_fire;
         if (w_done_fire) begin
            r_done_src     <= r_src;
            r_done_dst     <= r_dst;
            r_done_aborted <= r_aborted;
            if (r_route_count != 16'hFFFF) r_route_count <= r_route_count + 16'd1;
         end
      end
   end

   assign grant        = r_grant;
   assign in_valve     = r_in_valve;
   assign out_valve    = r_out_valve;
   assign busy         = r_busy;
   assign done         = r_done;
   assign done_src     = r_done_src;
   assign done_dst     = r_done_dst;
   assign done_aborted = r_done_aborted;
   assign route_count  = r_route_count;

endmodule
